// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - op encodings, FSM states and helpers for the multi-cycle mult/div unit
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - issue/result bundle between execute stage and the mult/div unit
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, md_op, A, B, input busy, hi, lo);
  modport slave  (input start, md_op, A, B, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit_divider.sv
// rtl/mult_div_unit_divider.sv - combinational signed/unsigned divide with MIPS-style zero-divisor and overflow results
module mult_div_unit_divider #(
  parameter int WIDTH = 32
) (
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, mag_q, mag_r;

  always_comb begin
    neg_a = is_signed & a[WIDTH-1];
    neg_b = is_signed & b[WIDTH-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
    mag_q = (mag_b == '0) ? '0 : mag_a / mag_b;
    mag_r = (mag_b == '0) ? '0 : mag_a % mag_b;
    if (b == '0) begin
      quo = '1;
      rem = a;
    end else if (is_signed && a == MOST_NEG && b == '1) begin
      quo = a;
      rem = '0;
    end else begin
      // quotient truncates toward zero, remainder follows the dividend's sign
      quo = (neg_a ^ neg_b) ? -mag_q : mag_q;
      rem = neg_a ? -mag_r : mag_r;
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle mult/div unit with HI/LO registers
// Divider present only when MDU_DIV_EN is defined; otherwise div/divu act as no-ops.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_unit_if.slave md
);
  localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  md_state_e          state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi, pend_hi_d, pend_lo, pend_lo_d;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic               is_mult, is_div, mult_signed;

  assign is_mult     = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU);
  assign mult_signed = (md.md_op == MD_MULT);

  // one multiplier serves both flavours: sign-extended operands yield the signed product in 2*WIDTH bits
  assign ext_a = {{WIDTH{mult_signed & md.A[WIDTH-1]}}, md.A};
  assign ext_b = {{WIDTH{mult_signed & md.B[WIDTH-1]}}, md.B};
  assign prod  = ext_a * ext_b;

`ifdef MDU_DIV_EN
  assign is_div = (md.md_op == MD_DIV) || (md.md_op == MD_DIVU);

  mult_div_unit_divider #(.WIDTH(WIDTH)) u_divider (
    .is_signed (md.md_op == MD_DIV),
    .a         (md.A),
    .b         (md.B),
    .quo       (div_quo),
    .rem       (div_rem)
  );
`else
  assign is_div  = 1'b0;
  assign div_quo = '0;
  assign div_rem = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_hi <= pend_hi_d;
      pend_lo <= pend_lo_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (md.start && (is_mult || is_div)) state_d = ST_RUN;
      ST_RUN:  if (cnt == CW'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // start is only honoured in IDLE; in RUN the counter alone drives progress
  always_comb begin
    cnt_d     = cnt;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi;
    pend_lo_d = pend_lo;
    case (state)
      ST_IDLE: begin
        if (md.start) begin
          if (is_mult) begin
            pend_hi_d = prod[2*WIDTH-1:WIDTH];
            pend_lo_d = prod[WIDTH-1:0];
            cnt_d     = CW'(MULT_CYCLES);
          end else if (is_div) begin
            pend_hi_d = div_rem;
            pend_lo_d = div_quo;
            cnt_d     = CW'(DIV_CYCLES);
          end else if (md.md_op == MD_MTHI) begin
            hi_d = md.A;
          end else if (md.md_op == MD_MTLO) begin
            lo_d = md.A;
          end
        end
      end
      ST_RUN: begin
        if (cnt == CW'(1)) begin
          hi_d  = pend_hi;
          lo_d  = pend_lo;
          cnt_d = '0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign md.busy = (state == ST_RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
endmodule
